gpio_ctrl: RTL and testbench

Parametrised general-purpose I/O controller between the processor core and its external pins, the successor of the fixed 8-bit `gpi`/`gpo` pair. Each input bit is synchronised, debounced and edge-detected, with sticky per-bit edge flags and a maskable interrupt. Outputs are held in a processor-writable register. The core accesses everything through a small single-cycle register bus.

---
 rtl/gpio_pkg.sv | 26 ++
 rtl/gpio_debounce.sv | 69 ++++++
 rtl/gpio_ctrl.sv | 104 ++++++++++
 tb/tb_gpio_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_pkg
//  Description : Shared constants and helpers for the gpio_ctrl block:
//                register addresses and the debounce counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    // Register map
    localparam logic [2:0] ADDR_IN     = 3'd0;
    localparam logic [2:0] ADDR_OUT    = 3'd1;
    localparam logic [2:0] ADDR_EDGE   = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN = 3'd3;
    localparam logic [2:0] ADDR_POL    = 3'd4;

    // Debounce counter width. The counter only has to reach DEB_CYCLES-2,
    // so clog2(DEB_CYCLES) bits always suffice; never narrower than 1 bit.
    function automatic int deb_cnt_width(input int deb_cycles);
        int w;
        w = $clog2(deb_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_debounce
//  Description : One-bit input conditioner: two-flop synchroniser followed
//                by a hold-time debouncer with single-cycle rise/fall
//                strobes that coincide with the update of 'stable'.
//  Ports       : clk    - system clock
//                rst    - synchronous active-high reset
//                din    - asynchronous pin input
//                stable - debounced level
//                rise   - high in the cycle 'stable' will go 0->1
//                fall   - high in the cycle 'stable' will go 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = deb_cnt_width(DEB_CYCLES);
    // Acceptance happens on the increment that would bring the count to
    // DEB_CYCLES-1, so the compare value is one below that.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 2);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;

    logic w_mismatch;
    logic w_accept;

    assign w_mismatch = r_sync2 ^ r_stable;
    assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stable = r_stable;
    assign rise   = w_accept &  r_sync2;
    assign fall   = w_accept & ~r_sync2;

endmodule : gpio_debounce
`default_nettype wire

// File: rtl/gpio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_ctrl
//  Description : Parametrised GPIO controller. Debounced inputs with sticky
//                polarity-selected edge flags and a maskable level
//                interrupt; a processor-writable output register; single-
//                cycle register bus with registered read data.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                gpi / gpo       - external input / output pins
//                addr, wr_en,
//                wdata           - register write port
//                rdata           - registered read data for addr
//                irq             - |(EDGE & IRQ_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpi,
    output logic [WIDTH-1:0] gpo,
    input  logic [2:0]       addr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge_set;
    logic [WIDTH-1:0] w_edge_clr;
    logic [WIDTH-1:0] w_rd;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_irq_en;
    logic [1:0]       r_pol;
    logic [WIDTH-1:0] r_rdata;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            gpio_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk    (clk),
                .rst    (rst),
                .din    (gpi[gi]),
                .stable (w_in[gi]),
                .rise   (w_rise[gi]),
                .fall   (w_fall[gi])
            );
        end
    endgenerate

    assign w_edge_set = (w_rise & {WIDTH{r_pol[0]}}) | (w_fall & {WIDTH{r_pol[1]}});
    assign w_edge_clr = (wr_en && (addr == ADDR_EDGE)) ? wdata : '0;

    // Read mux sampled into r_rdata; unmapped addresses return zero.
    always_comb begin
        w_rd = '0;
        case (addr)
            ADDR_IN:     w_rd = w_in;
            ADDR_OUT:    w_rd = r_out;
            ADDR_EDGE:   w_rd = r_edge;
            ADDR_IRQ_EN: w_rd = r_irq_en;
            ADDR_POL:    w_rd[1:0] = r_pol;
            default:     w_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_edge   <= '0;
            r_irq_en <= '0;
            r_pol    <= '0;
            r_rdata  <= '0;
        end else begin
            r_rdata <= w_rd;
            // Set is OR-ed in after the clear so a simultaneous edge wins.
            r_edge  <= (r_edge & ~w_edge_clr) | w_edge_set;
            if (wr_en) begin
                case (addr)
                    ADDR_OUT:    r_out    <= wdata;
                    ADDR_IRQ_EN: r_irq_en <= wdata;
                    ADDR_POL:    r_pol    <= wdata[1:0];
                    default:     ;
                endcase
            end
        end
    end

    assign gpo   = r_out;
    assign rdata = r_rdata;
    assign irq   = |(r_edge & r_irq_en);

endmodule : gpio_ctrl
`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_ctrl
//  Description : Self-checking bench for gpio_ctrl (WIDTH=8, DEB_CYCLES=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_ctrl;
    import gpio_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gpi = 8'h00;
    logic [7:0] gpo;
    logic [2:0] addr = 3'd0;
    logic       wr_en = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       irq;

    int n_pass  = 0;
    int n_total = 0;

    gpio_ctrl #(
        .WIDTH      (8),
        .DEB_CYCLES (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .gpi   (gpi),
        .gpo   (gpo),
        .addr  (addr),
        .wr_en (wr_en),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
        logic [7:0] exp_gpo;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        addr  = a;
        wr_en = 1'b0;
        tick();
        d = rdata;
    endtask

    initial begin
        logic [7:0] v;
        logic       glitch_seen;

        // Register-access vectors, applied after the edge scenarios.
        vecs[0] = '{1'b1, ADDR_OUT,    8'h5A, 8'h5A, 8'h5A};
        vecs[1] = '{1'b1, ADDR_IN,     8'h33, 8'h01, 8'h5A};
        vecs[2] = '{1'b1, 3'd6,        8'h77, 8'h00, 8'h5A};
        vecs[3] = '{1'b0, 3'd5,        8'h00, 8'h00, 8'h5A};
        vecs[4] = '{1'b0, 3'd7,        8'h00, 8'h00, 8'h5A};
        vecs[5] = '{1'b1, ADDR_IRQ_EN, 8'hC3, 8'hC3, 8'h5A};
        vecs[6] = '{1'b1, ADDR_POL,    8'hFF, 8'h03, 8'h5A};
        vecs[7] = '{1'b0, ADDR_OUT,    8'h00, 8'h5A, 8'h5A};
        vecs[8] = '{1'b0, ADDR_EDGE,   8'h00, 8'h00, 8'h5A};

        // ---------------- Reset ----------------
        tick();
        tick();
        rst = 1'b0;
        wr(ADDR_OUT, 8'hAA);
        chk("pre_reset_gpo", gpo, 8'hAA);

        gpi = 8'hFF;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_gpo", gpo, 8'h00);
            chk("rst_rdata", rdata, 8'h00);
            chk("rst_irq", {7'b0, irq}, 8'h00);
        end
        rst  = 1'b0;
        addr = ADDR_IN;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 1) begin
                chk("rel_gpo", gpo, 8'h00);
                chk("rel_rdata", rdata, 8'h00);
                chk("rel_irq", {7'b0, irq}, 8'h00);
            end
            if (k == 17) chk("rel_in_c17", rdata, 8'h00);
            if (k == 18) chk("rel_in_c18", rdata, 8'hFF);
        end
        gpi = 8'h00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // ---------------- Debounce ----------------
        wr(ADDR_POL, 8'h03);
        wr(ADDR_IRQ_EN, 8'h01);
        addr = ADDR_IN;
        glitch_seen = 1'b0;
        gpi[0] = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        gpi[0] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (rdata != 8'h00 || irq) glitch_seen = 1'b1;
        end
        chk("glitch_ignored", {7'b0, glitch_seen}, 8'h00);
        rd(ADDR_EDGE, v);
        chk("glitch_edge", v, 8'h00);

        addr = ADDR_IN;
        gpi[0] = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 16) chk("deb_irq_e16", {7'b0, irq}, 8'h00);
            if (k == 17) chk("deb_irq_e17", {7'b0, irq}, 8'h01);
            if (k == 17) chk("deb_in_c17", rdata, 8'h00);
            if (k == 18) chk("deb_in_c18", rdata, 8'h01);
        end
        wr(ADDR_EDGE, 8'hFF);
        chk("deb_clr_irq", {7'b0, irq}, 8'h00);

        // ---------------- Polarity and interrupt ----------------
        wr(ADDR_POL, 8'h02);
        wr(ADDR_IRQ_EN, 8'h02);
        gpi = 8'h03;
        for (int k = 0; k < 20; k++) tick();
        chk("pol_rise_irq", {7'b0, irq}, 8'h00);
        rd(ADDR_EDGE, v);
        chk("pol_rise_edge", v, 8'h00);
        gpi = 8'h01;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 16) chk("pol_fall_irq_e16", {7'b0, irq}, 8'h00);
            if (k == 17) chk("pol_fall_irq_e17", {7'b0, irq}, 8'h01);
        end
        rd(ADDR_EDGE, v);
        chk("pol_fall_edge", v, 8'h02);

        // ---------------- Set/clear collision ----------------
        gpi = 8'h03;
        for (int k = 0; k < 20; k++) tick();
        chk("coll_pre_irq", {7'b0, irq}, 8'h01);
        gpi = 8'h01;
        for (int k = 0; k < 16; k++) tick();
        addr  = ADDR_EDGE;
        wdata = 8'h02;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("coll_irq", {7'b0, irq}, 8'h01);
        rd(ADDR_EDGE, v);
        chk("coll_edge", v, 8'h02);
        wr(ADDR_EDGE, 8'h02);
        chk("coll_clr_irq", {7'b0, irq}, 8'h00);
        rd(ADDR_EDGE, v);
        chk("coll_clr_edge", v, 8'h00);

        // ---------------- Register access table ----------------
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) wr(vecs[i].a, vecs[i].d);
            rd(vecs[i].a, v);
            chk($sformatf("vec%0d_rdata", i), v, vecs[i].exp_rd);
            chk($sformatf("vec%0d_gpo", i), gpo, vecs[i].exp_gpo);
        end

        // Read of a register written on the same edge returns the old value.
        addr  = ADDR_OUT;
        wdata = 8'hA5;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("same_edge_old", rdata, 8'h5A);
        chk("same_edge_gpo", gpo, 8'hA5);
        tick();
        chk("same_edge_new", rdata, 8'hA5);

        // ---------------- Reset mid-debounce ----------------
        gpi = 8'h05;
        for (int k = 0; k < 8; k++) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_gpo", gpo, 8'h00);
        chk("mid_rst_rdata", rdata, 8'h00);
        rst  = 1'b0;
        addr = ADDR_IN;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 17) chk("mid_in_c17", rdata, 8'h00);
            if (k == 18) chk("mid_in_c18", rdata, 8'h05);
        end
        rd(ADDR_EDGE, v);
        chk("mid_edge", v, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_gpio_ctrl
`default_nettype wire
